// File: rtl/piso_rr_scheduler.sv
// rtl/piso_rr_scheduler.sv - round-robin arbiter feeding one parallel-in serial-out word serializer
module piso_rr_scheduler #(
   parameter  int NUM_REQ        = 2,
   parameter  int MAX_INPUT_SIZE = 5,
   parameter  int WORD_SIZE      = 16,
   localparam int SW             = $clog2(MAX_INPUT_SIZE + 1),
   localparam int IW             = $clog2(NUM_REQ)
) (
   input  logic                                                clk_i,
   input  logic                                                reset_n_i,
   input  logic [NUM_REQ-1:0]                                  req_valid_i,
   output logic [NUM_REQ-1:0]                                  req_ready_o,
   input  logic [NUM_REQ-1:0][MAX_INPUT_SIZE-1:0][WORD_SIZE-1:0] req_data_i,
   input  logic [NUM_REQ-1:0][SW-1:0]                          req_size_i,
   output logic                                                valid_o,
   input  logic                                                ready_i,
   output logic [WORD_SIZE-1:0]                                data_o,
   output logic [IW-1:0]                                       src_o,
   output logic                                                last_o
);

   typedef enum logic {eIDLE = 1'b0, eSERIAL = 1'b1} state_e;

   state_e                                   state_q, state_d;
   logic [IW-1:0]                            ptr_q, ptr_d;
   logic [SW-1:0]                            count_q, count_d;
   logic [SW-1:0]                            size_q, size_d;
   logic [IW-1:0]                            src_q, src_d;
   logic [MAX_INPUT_SIZE-1:0][WORD_SIZE-1:0] data_q, data_d;
   // Output hold registers: keep the last emitted word/source visible while idle,
   // independent of a later zero-size grant overwriting the buffer.
   logic [WORD_SIZE-1:0]                     dout_q, dout_d;
   logic [IW-1:0]                            src_hold_q, src_hold_d;

   logic          gnt_found;
   logic [IW-1:0] gnt_idx;
   int            scan_idx;
   logic [SW-1:0] gnt_size_raw;
   logic [SW-1:0] eff_size;
   logic          handshake;
   logic          accept;
   logic          is_last;

   // Round-robin search: first valid requester at or above ptr_q, wrapping around
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = int'(ptr_q) + i;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!gnt_found && req_valid_i[IW'(scan_idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(scan_idx);
         end
      end
   end

   // Handshake / clamp / word-position decode shared by FSM and datapath
   always_comb begin
      gnt_size_raw = req_size_i[gnt_idx];
      eff_size     = (gnt_size_raw > SW'(MAX_INPUT_SIZE)) ? SW'(MAX_INPUT_SIZE) : gnt_size_raw;
      handshake    = (state_q == eIDLE) && gnt_found;
      accept       = (state_q == eSERIAL) && ready_i;
      is_last      = (count_q == (size_q - SW'(1)));
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= eIDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: zero-size grants are consumed without leaving eIDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         eIDLE:   if (handshake && (eff_size != '0)) state_d = eSERIAL;
         eSERIAL: if (accept && is_last)             state_d = eIDLE;
         default: state_d = eIDLE;
      endcase
   end

   // FSM outputs: one-hot grant while idle, serializer view while serial
   always_comb begin
      req_ready_o = '0;
      valid_o     = 1'b0;
      last_o      = 1'b0;
      data_o      = dout_q;
      src_o       = src_hold_q;
      case (state_q)
         eIDLE: begin
            if (gnt_found && reset_n_i) begin
               req_ready_o[gnt_idx] = 1'b1;
            end
         end
         eSERIAL: begin
            valid_o = 1'b1;
            data_o  = data_q[count_q];
            src_o   = src_q;
            last_o  = is_last;
         end
         default: ;
      endcase
   end

   // Datapath next-state: capture on grant, step on downstream accept
   always_comb begin
      ptr_d      = ptr_q;
      count_d    = count_q;
      size_d     = size_q;
      src_d      = src_q;
      data_d     = data_q;
      dout_d     = dout_q;
      src_hold_d = src_hold_q;
      if (handshake) begin
         data_d  = req_data_i[gnt_idx];
         size_d  = eff_size;
         src_d   = gnt_idx;
         count_d = '0;
         ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
      if (state_q == eSERIAL) begin
         dout_d     = data_q[count_q];
         src_hold_d = src_q;
      end
      if (accept) begin
         count_d = count_q + SW'(1);
      end
   end

   // Datapath registers, cleared asynchronously so a vector in flight is abandoned
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ptr_q      <= '0;
         count_q    <= '0;
         size_q     <= '0;
         src_q      <= '0;
         data_q     <= '0;
         dout_q     <= '0;
         src_hold_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         size_q     <= size_d;
         src_q      <= src_d;
         data_q     <= data_d;
         dout_q     <= dout_d;
         src_hold_q <= src_hold_d;
      end
   end

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// tb/tb_piso_rr_scheduler.sv - directed self-checking bench for piso_rr_scheduler
module tb_piso_rr_scheduler;

   localparam int NR = 2;
   localparam int MX = 5;
   localparam int WS = 16;
   localparam int SW = 3;
   localparam int IW = 1;

   logic                         clk;
   logic                         reset_n;
   logic [NR-1:0]                req_valid;
   logic [NR-1:0]                req_ready;
   logic [NR-1:0][MX-1:0][WS-1:0] req_data;
   logic [NR-1:0][SW-1:0]        req_size;
   logic                         valid;
   logic                         ready;
   logic [WS-1:0]                data;
   logic [IW-1:0]                src;
   logic                         last;

   int checks   = 0;
   int failures = 0;

   piso_rr_scheduler #(.NUM_REQ(NR), .MAX_INPUT_SIZE(MX), .WORD_SIZE(WS)) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_data_i  (req_data),
      .req_size_i  (req_size),
      .valid_o     (valid),
      .ready_i     (ready),
      .data_o      (data),
      .src_o       (src),
      .last_o      (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [15:0] d, input logic s, input logic l);
      chk({tag, ".valid"}, 32'(valid), 32'd1);
      chk({tag, ".data"},  32'(data),  32'(d));
      chk({tag, ".src"},   32'(src),   32'(s));
      chk({tag, ".last"},  32'(last),  32'(l));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input int sz, input logic [15:0] base);
      for (int i = 0; i < MX; i++) begin
         req_data[r][i] = base + 16'(i);
      end
      req_size[r] = SW'(sz);
   endtask

   initial begin
      int w;
      int p;
      reset_n   = 1'b0;
      req_valid = 2'b11;
      req_data  = '0;
      req_size  = '0;
      ready     = 1'b1;
      #2;
      chk("rst.valid", 32'(valid),     32'd0);
      chk("rst.ready", 32'(req_ready), 32'd0);
      chk("rst.data",  32'(data),      32'd0);
      chk("rst.src",   32'(src),       32'd0);
      chk("rst.last",  32'(last),      32'd0);
      tick();
      tick();
      reset_n = 1'b1;

      // contention: req0, req1, req0 with one bubble between vectors
      set_req(0, 2, 16'h0010);
      set_req(1, 2, 16'h0020);
      req_valid = 2'b11;
      #1;
      chk("cont.gnt0", 32'(req_ready), 32'h1);
      tick();
      #1;
      chk("cont.serial_ready", 32'(req_ready), 32'h0);
      chk_word("cont.v0w0", 16'h0010, 1'b0, 1'b0);
      tick();
      chk_word("cont.v0w1", 16'h0011, 1'b0, 1'b1);
      tick();
      chk("cont.bubble1.valid", 32'(valid),     32'd0);
      chk("cont.gnt1",          32'(req_ready), 32'h2);
      tick();
      chk_word("cont.v1w0", 16'h0020, 1'b1, 1'b0);
      tick();
      chk_word("cont.v1w1", 16'h0021, 1'b1, 1'b1);
      tick();
      chk("cont.bubble2.valid", 32'(valid),     32'd0);
      chk("cont.gnt2",          32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      chk_word("cont.v2w0", 16'h0010, 1'b0, 1'b0);
      tick();
      chk_word("cont.v2w1", 16'h0011, 1'b0, 1'b1);
      tick();

      // single requester (pointer at 1 wraps to 0)
      set_req(0, 3, 16'h00A0);
      req_valid = 2'b01;
      #1;
      chk("single.gnt",   32'(req_ready), 32'h1);
      chk("single.valid", 32'(valid),     32'd0);
      tick();
      req_valid = 2'b00;
      #1;
      chk_word("single.w0", 16'h00A0, 1'b0, 1'b0);
      tick();
      chk_word("single.w1", 16'h00A1, 1'b0, 1'b0);
      tick();
      chk_word("single.w2", 16'h00A2, 1'b0, 1'b1);
      tick();
      chk("single.idle.valid", 32'(valid), 32'd0);
      chk("single.idle.last",  32'(last),  32'd0);
      chk("single.idle.data",  32'(data),  32'h00A2);
      chk("single.idle.src",   32'(src),   32'd0);

      // backpressure: ready pattern 1,0,0 repeating, size 4 on req1
      set_req(1, 4, 16'h0030);
      req_valid = 2'b10;
      #1;
      chk("bp.gnt", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      w = 0;
      p = 0;
      while (w < 4 && p < 20) begin
         ready = (p % 3 == 0);
         #1;
         chk_word("bp.word", 16'h0030 + 16'(w), 1'b1, (w == 3));
         tick();
         if (ready) w++;
         p++;
      end
      chk("bp.words_done", 32'(w), 32'd4);
      chk("bp.cycles",     32'(p), 32'd10);
      ready = 1'b1;
      #1;
      chk("bp.idle.valid", 32'(valid), 32'd0);
      chk("bp.idle.data",  32'(data),  32'h0033);

      // zero-size vector consumed, pointer advances
      set_req(0, 0, 16'h0000);
      req_valid = 2'b01;
      #1;
      chk("zero.gnt", 32'(req_ready), 32'h1);
      tick();
      set_req(1, 1, 16'h0040);
      req_valid = 2'b11;
      #1;
      chk("zero.no_valid", 32'(valid),     32'd0);
      chk("zero.ptr_adv",  32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      #1;
      chk_word("size1.w0", 16'h0040, 1'b1, 1'b1);
      tick();
      chk("size1.idle.valid", 32'(valid), 32'd0);

      // oversize request clamped to MAX_INPUT_SIZE words
      set_req(0, 7, 16'h0050);
      req_valid = 2'b01;
      #1;
      chk("clamp.gnt", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      for (int i = 0; i < MX; i++) begin
         #1;
         chk_word("clamp.word", 16'h0050 + 16'(i), 1'b0, (i == MX - 1));
         tick();
      end
      chk("clamp.idle.valid", 32'(valid), 32'd0);
      chk("clamp.idle.data",  32'(data),  32'h0054);

      // reset during word 1 of 3 abandons the vector
      set_req(1, 3, 16'h0060);
      req_valid = 2'b10;
      #1;
      chk("rmid.gnt", 32'(req_ready), 32'h2);
      tick();
      #1;
      chk_word("rmid.w0", 16'h0060, 1'b1, 1'b0);
      tick();
      chk_word("rmid.w1", 16'h0061, 1'b1, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("rmid.valid", 32'(valid),     32'd0);
      chk("rmid.data",  32'(data),      32'd0);
      chk("rmid.src",   32'(src),       32'd0);
      chk("rmid.ready", 32'(req_ready), 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      set_req(0, 1, 16'h0070);
      req_valid = 2'b11;
      #1;
      chk("rmid.post.valid", 32'(valid),     32'd0);
      chk("rmid.post.gnt",   32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      chk_word("rmid.post.w0", 16'h0070, 1'b0, 1'b1);
      tick();
      chk("rmid.post.idle", 32'(valid), 32'd0);
      tick();
      chk("rmid.no_residual", 32'(valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piso_rr_scheduler.md
PISO_RR_SCHEDULER -- requirements
Module: piso_rr_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters (>=2); MAX_INPUT_SIZE, default 5, maximum words per vector; WORD_SIZE, default 16, bits per word.
REQ-002 Derived widths SHALL be: SW = $clog2(MAX_INPUT_SIZE+1) for size fields; IW = $clog2(NUM_REQ) for requester index.
REQ-003 Ports SHALL be:
- clk_i  input  1  clock; one clock domain, all state on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  NUM_REQ  per-requester valid.
- req_ready_o  output  NUM_REQ  per-requester ready (grant).
- req_data_i  input  NUM_REQ x MAX_INPUT_SIZE x WORD_SIZE  parallel vectors; word 0 is emitted first.
- req_size_i  input  NUM_REQ x SW  valid word count per requester.
- valid_o  output  1  serial word valid.
- ready_i  input  1  downstream ready.
- data_o  output  WORD_SIZE  serial word.
- src_o  output  IW  index of the requester owning data_o.
- last_o  output  1  data_o is the final word of its vector.

Function
REQ-004 The block SHALL arbitrate NUM_REQ parallel producers onto one shared serializer, round-robin, one vector at a time.
REQ-005 The FSM SHALL have two states: eIDLE and eSERIAL.
REQ-006 Grant in eIDLE SHALL go to the first valid requester searching upward (with wrap) from pointer ptr_r.
REQ-007 req_ready_o SHALL be one-hot at the granted index in eIDLE; it SHALL be all-zero in eSERIAL or when no requester is valid.
REQ-008 A grant handshake (req_valid_i[g] && req_ready_o[g]) SHALL register req_data_i[g], the effective size, and g into src_r, reset count_r to 0, and set ptr_r = (g+1) mod NUM_REQ.
REQ-009 The effective size SHALL be req_size_i[g], clamped to MAX_INPUT_SIZE if larger.
REQ-010 Zero-size vector: a handshake with effective size 0 SHALL be consumed, emit no word, advance ptr_r, and leave the FSM in eIDLE.
REQ-011 eIDLE -> eSERIAL SHALL occur on a handshake with nonzero effective size; the first valid_o SHALL be in the next cycle (1-cycle latency).
REQ-012 In eSERIAL, outputs SHALL be: valid_o=1, data_o=data_r[count_r], src_o=src_r, last_o=(count_r==size_r-1).
REQ-013 In eSERIAL, ready_i=1 SHALL advance count_r by 1; if last_o is also 1, the FSM SHALL return to eIDLE.
REQ-014 Stall: while valid_o && !ready_i, data_o, src_o and last_o SHALL hold stable.
REQ-015 Back-to-back vectors SHALL incur exactly one bubble cycle: the last word is accepted at cycle M, the next grant occurs at M+1, and the next valid_o rises at M+2.
REQ-016 Request changes during eSERIAL SHALL NOT affect the vector in flight.
REQ-017 The datapath SHALL use a single registered data buffer; it SHALL NOT store multiple requesters' vectors.
REQ-018 In eIDLE, valid_o and last_o SHALL be 0, and data_o and src_o SHALL hold their last values.

Reset
REQ-019 Asserting reset_n_i low SHALL, asynchronously, set: state=eIDLE, ptr_r=0, count_r=0, size_r=0, src_r=0, data_r=0.
REQ-020 While reset_n_i is low, the block SHALL drive: valid_o=0, last_o=0, data_o=0, src_o=0, req_ready_o=0.
REQ-021 Reset asserted mid-vector SHALL abandon the vector; no further words of it SHALL be emitted after release.
REQ-022 The first grant after reset release SHALL search from index 0.

Verification
REQ-023 Single requester: req0 valid, size 3, words {A,B,C}, ready_i=1 -> grant in cycle 0; valid_o in cycles 1-3 with data_o A,B,C; last_o only in cycle 3; src_o=0.
REQ-024 Contention: req0 and req1 both valid continuously, size 2 -> order req0, req1, req0; one bubble between vectors; ptr_r alternates.
REQ-025 Backpressure: size 4, ready_i toggling 1,0,0,1,... -> each word holds while ready_i=0; no word is dropped or duplicated; last_o is asserted on word 3 only.
REQ-026 Size boundaries:
- size 0 -> consumed, no valid_o, pointer advances.
- size 7 with MAX=5 -> exactly 5 words.
- size 1 -> one word with last_o=1.
REQ-027 Reset mid-vector: reset_n_i low during word 1 of 3 -> valid_o=0 immediately; after release, no residual words; the next grant goes to the lowest valid index.
